core_run_ctrl: RTL and testbench
================================

Name: core_run_ctrl

Overview:
- Parametrised run controller that replaces the hand-timed reset pulse around top_pipelining.
- Sequences the core reset, then monitors retirement and memory stores to detect end-of-program (tohost write or self-loop) or a timeout.
- Freezes the core and reports verdict, cause, cycle and retired-instruction counts.
- Sits between the clock/reset source and top_pipelining; usable in simulation and on FPGA.

Parameters:
XLEN, 32, width of PC, store address and store data
CNT_W, 32, width of cycle/instret counters
RST_HOLD, 4, cycles core_rst held high after start (min 1)
DRAIN_CYCLES, 4, cycles between halt detect and done, letting pipeline stages retire (min 0)
LOOP_N, 8, consecutive retirements at the same PC that declare a self-loop halt (min 2)
TIMEOUT, 100000, RUN-state cycle limit (min 1)
TOHOST_ADDR, 32'h0000_1000, store address for pass/fail write

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  level/pulse; begins a run from IDLE or DONE
retire_valid  in  1  one instruction retired this cycle
retire_pc  in  XLEN  PC of retiring instruction
st_valid  in  1  data-memory store this cycle
st_addr  in  XLEN  store address
st_data  in  XLEN  store data
core_rst  out  1  active-high reset to core
core_stall  out  1  freezes core (high in DONE)
running  out  1  high in RUN and DRAIN
done  out  1  high in DONE
pass  out  1  valid when done
halt_cause  out  2  0 none, 1 tohost, 2 self-loop, 3 timeout
fail_code  out  XLEN  st_data>>1 of failing tohost write, else 0
cycle_count  out  CNT_W  cycles spent in RUN+DRAIN
instret_count  out  CNT_W  retire_valid pulses in RUN+DRAIN

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, core_rst=1, core_stall=0, running=0, done=0, pass=0, halt_cause=0, fail_code=0, counters=0, loop tracker cleared. Reset mid-run aborts immediately; no verdict is retained.
- States: IDLE -> RESET_HOLD -> RUN -> DRAIN -> DONE.
- IDLE:
  - core_rst=1.
  - start=1 -> RESET_HOLD; clears counters, cause, fail_code and loop tracker.
- RESET_HOLD:
  - core_rst=1 for exactly RST_HOLD cycles, then -> RUN.
  - core_rst falls on the first RUN cycle.
  - start is ignored.
- RUN:
  - core_rst=0.
  - cycle_count +1 per cycle. instret_count +1 per retire_valid. Both saturate at all-ones; no wrap.
- Loop tracker (RUN only):
  - On retire_valid, same PC as the last retired PC: repeat count +1; different PC: count reloads to 1.
  - Reaching LOOP_N declares halt, cause 2, pass=1.
- Tohost (RUN only):
  - st_valid with st_addr==TOHOST_ADDR and st_data!=0 declares halt, cause 1.
  - pass = (st_data==1). Otherwise fail_code=st_data>>1.
  - A store of 0 is ignored.
- Timeout (RUN only): cycle_count reaching TIMEOUT declares halt, cause 3, pass=0.
- Same-cycle priority: tohost > self-loop > timeout. Only the winner is recorded.
- Halt: latches cause/pass/fail_code and moves to DRAIN the next cycle.
- DRAIN:
  - Lasts DRAIN_CYCLES cycles; counters keep counting.
  - Further tohost/loop/timeout events are ignored.
  - DRAIN_CYCLES=0 goes straight to DONE.
- DONE:
  - done=1, core_stall=1, core_rst=0. Counters, pass, cause and fail_code hold.
  - start=1 -> RESET_HOLD (restart; all results cleared).
- Registered outputs; done rises the cycle after the final DRAIN cycle.
- start held high continuously triggers a single run per IDLE/DONE visit, with no re-trigger in RUN.

Test Plan:
- Reset then start pulse, RST_HOLD=4 -> core_rst high exactly 4 cycles after start, running=1 on cycle 5, cycle_count=0 at entry.
- In RUN, store st_addr=0x1000, st_data=1 -> after DRAIN_CYCLES=4: done=1, pass=1, halt_cause=1, fail_code=0, core_stall=1.
- Store 0x1000 data 0x0000_0007 -> done, pass=0, halt_cause=1, fail_code=3. A store of data 0 to 0x1000 beforehand causes no halt.
- Retire PC 0x40 eight consecutive times (LOOP_N=8) -> halt_cause=2, pass=1. Seven repeats then PC 0x44 -> no halt, count reloads.
- TIMEOUT=50 with no events -> halt_cause=3, pass=0 after cycle_count=50. Tohost and 8th loop retirement in the same cycle -> halt_cause=1.
- Assert rst low during DRAIN -> all outputs return to reset values immediately. Start from DONE -> counters cleared, RESET_HOLD re-entered.

Source files
------------

// File: rtl/core_run_ctrl.sv
// Run controller: sequences the core reset, watches retirement and stores for
// end-of-program (tohost write, self-loop) or timeout, then freezes the core.
module core_run_ctrl #(
    parameter int               XLEN         = 32,
    parameter int               CNT_W        = 32,
    parameter int               RST_HOLD     = 4,
    parameter int               DRAIN_CYCLES = 4,
    parameter int               LOOP_N       = 8,
    parameter int               TIMEOUT      = 100000,
    parameter logic [XLEN-1:0]  TOHOST_ADDR  = 32'h0000_1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             retire_valid,
    input  logic [XLEN-1:0]  retire_pc,
    input  logic             st_valid,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    output logic             core_rst,
    output logic             core_stall,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic [1:0]       halt_cause,
    output logic [XLEN-1:0]  fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);
    // state      | meaning
    // S_IDLE     | core held in reset, waiting for start
    // S_HOLD     | core_rst asserted for RST_HOLD cycles
    // S_RUN      | core executing, halt detection armed
    // S_DRAIN    | halt latched, pipeline allowed to retire
    // S_DONE     | core frozen, verdict valid
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HOLD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int HW = $clog2(RST_HOLD + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 2);
    localparam int LW = $clog2(LOOP_N + 1);

    localparam logic [HW-1:0]    HOLD_LOAD  = HW'(RST_HOLD - 1);
    localparam logic [DW-1:0]    DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;
    localparam logic [LW-1:0]    LOOP_TC    = LW'(LOOP_N);
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT);

    logic [2:0]       state;
    logic [HW-1:0]    hold_cnt;
    logic [DW-1:0]    drain_cnt;
    logic [XLEN-1:0]  last_pc;
    logic [LW-1:0]    rep_cnt;

    logic [CNT_W-1:0] cyc_inc;
    logic [CNT_W-1:0] ins_inc;
    logic [LW-1:0]    rep_next;
    logic             tohost_hit;
    logic             loop_hit;
    logic             timeout_hit;
    logic             halt;

    always_comb begin
        cyc_inc     = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
        ins_inc     = (&instret_count) ? instret_count : instret_count + 1'b1;
        // rep_cnt==0 marks an empty tracker so the first retirement always reloads
        rep_next    = (rep_cnt != '0 && retire_pc == last_pc) ? rep_cnt + LW'(1) : LW'(1);
        tohost_hit  = st_valid && (st_addr == TOHOST_ADDR) && (st_data != '0);
        loop_hit    = retire_valid && (rep_next == LOOP_TC);
        timeout_hit = (cyc_inc == TIMEOUT_TC);
        halt        = (state == S_RUN) && (tohost_hit || loop_hit || timeout_hit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            hold_cnt      <= '0;
            drain_cnt     <= '0;
            last_pc       <= '0;
            rep_cnt       <= '0;
            core_rst      <= 1'b1;
            core_stall    <= 1'b0;
            running       <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            halt_cause    <= 2'd0;
            fail_code     <= '0;
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state         <= S_HOLD;
                        hold_cnt      <= HOLD_LOAD;
                        last_pc       <= '0;
                        rep_cnt       <= '0;
                        core_rst      <= 1'b1;
                        core_stall    <= 1'b0;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        halt_cause    <= 2'd0;
                        fail_code     <= '0;
                        cycle_count   <= '0;
                        instret_count <= '0;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == '0) begin
                        state    <= S_RUN;
                        core_rst <= 1'b0;
                        running  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                S_RUN: begin
                    cycle_count <= cyc_inc;
                    if (retire_valid) begin
                        instret_count <= ins_inc;
                        last_pc       <= retire_pc;
                        rep_cnt       <= rep_next;
                    end
                    if (halt) begin
                        if (tohost_hit) begin
                            halt_cause <= 2'd1;
                            pass       <= (st_data == XLEN'(1));
                            fail_code  <= (st_data == XLEN'(1)) ? '0 : (st_data >> 1);
                        end else if (loop_hit) begin
                            halt_cause <= 2'd2;
                            pass       <= 1'b1;
                        end else begin
                            halt_cause <= 2'd3;
                            pass       <= 1'b0;
                        end
                        if (DRAIN_CYCLES == 0) begin
                            state      <= S_DONE;
                            running    <= 1'b0;
                            done       <= 1'b1;
                            core_stall <= 1'b1;
                        end else begin
                            state     <= S_DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end
                    end
                end
                S_DRAIN: begin
                    cycle_count <= cyc_inc;
                    if (retire_valid) begin
                        instret_count <= ins_inc;
                    end
                    if (drain_cnt == '0) begin
                        state      <= S_DONE;
                        running    <= 1'b0;
                        done       <= 1'b1;
                        core_stall <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: tests push the expected verdict when they
// issue a run; a monitor pops and compares on every rising edge of done.
module tb_core_run_ctrl;
    localparam int XLEN = 32;
    localparam int CNT_W = 32;
    localparam int RST_HOLD = 4;
    localparam int DRAIN = 4;
    localparam int TMO = 50;
    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             retire_valid = 1'b0;
    logic [XLEN-1:0]  retire_pc = '0;
    logic             st_valid = 1'b0;
    logic [XLEN-1:0]  st_addr = '0;
    logic [XLEN-1:0]  st_data = '0;
    logic             core_rst, core_stall, running, done, pass;
    logic [1:0]       halt_cause;
    logic [XLEN-1:0]  fail_code;
    logic [CNT_W-1:0] cycle_count, instret_count;

    core_run_ctrl #(
        .XLEN(XLEN), .CNT_W(CNT_W), .RST_HOLD(RST_HOLD), .DRAIN_CYCLES(DRAIN),
        .LOOP_N(8), .TIMEOUT(TMO), .TOHOST_ADDR(TOHOST)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .retire_valid(retire_valid), .retire_pc(retire_pc),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .core_rst(core_rst), .core_stall(core_stall), .running(running),
        .done(done), .pass(pass), .halt_cause(halt_cause), .fail_code(fail_code),
        .cycle_count(cycle_count), .instret_count(instret_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        p;
        logic [1:0]  c;
        logic [31:0] f;
        logic [31:0] cyc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic done_q = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_pass", pass, e.p);
                chk("sb_cause", halt_cause, e.c);
                chk("sb_fail_code", fail_code, e.f);
                chk("sb_cycle_count", cycle_count, e.cyc);
                chk("sb_instret", instret_count, e.ins);
            end
        end
        done_q = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic p, input logic [1:0] c, input logic [31:0] f,
                        input logic [31:0] cyc, input logic [31:0] ins);
        exp_t e;
        e.p = p; e.c = c; e.f = f; e.cyc = cyc; e.ins = ins;
        sb.push_back(e);
    endtask

    task automatic step(input logic rv, input logic [31:0] pc, input logic sv,
                        input logic [31:0] sa, input logic [31:0] sd);
        retire_valid = rv; retire_pc = pc;
        st_valid = sv; st_addr = sa; st_data = sd;
        tick();
    endtask

    task automatic idle_inputs();
        retire_valid = 1'b0; retire_pc = '0;
        st_valid = 1'b0; st_addr = '0; st_data = '0;
    endtask

    // start pulse, then walk through RESET_HOLD checking core_rst each cycle
    task automatic do_start(input logic keep);
        start = 1'b1;
        tick();
        if (!keep) start = 1'b0;
        chk("hold_cycle_count_clr", cycle_count, 0);
        chk("hold_done_clr", done, 0);
        for (int i = 0; i < RST_HOLD; i++) begin
            chk("hold_core_rst", core_rst, 1);
            chk("hold_running", running, 0);
            tick();
        end
        chk("run_core_rst", core_rst, 0);
        chk("run_running", running, 1);
        chk("run_cycle_entry", cycle_count, 0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && !done; i++) tick();
        chk("done_reached", done, 1);
        chk("done_stall", core_stall, 1);
        chk("done_core_rst", core_rst, 0);
        chk("done_running", running, 0);
    endtask

    initial begin
        #12;
        chk("rst_core_rst", core_rst, 1);
        chk("rst_stall", core_stall, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_cause", halt_cause, 0);
        chk("rst_cycles", cycle_count, 0);
        tick();
        rst = 1'b1;
        tick();

        // tohost pass, with a retirement and a late tohost write during drain
        do_start(1'b0);
        push(1'b1, 2'd1, 32'd0, 32'd7, 32'd4);
        step(1, 32'h0, 0, 0, 0);
        step(1, 32'h4, 0, 0, 0);
        step(1, 32'h8, 1, TOHOST, 1);
        step(1, 32'hC, 1, TOHOST, 3);
        idle_inputs();
        wait_done();

        // restart from DONE; zero store and wrong address ignored, then fail code 7>>1
        do_start(1'b0);
        push(1'b0, 2'd1, 32'd3, 32'd7, 32'd0);
        step(0, 0, 1, TOHOST, 0);
        step(0, 0, 1, 32'h2000, 1);
        step(0, 0, 1, TOHOST, 7);
        idle_inputs();
        wait_done();

        // seven repeats of 0x40 then 0x44 reloads the count; eighth 0x44 halts
        do_start(1'b0);
        push(1'b1, 2'd2, 32'd0, 32'd19, 32'd15);
        for (int i = 0; i < 7; i++) step(1, 32'h40, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 32'h44, 0, 0, 0);
        idle_inputs();
        wait_done();

        // plain eight-in-a-row self loop
        do_start(1'b0);
        push(1'b1, 2'd2, 32'd0, 32'd12, 32'd8);
        for (int i = 0; i < 8; i++) step(1, 32'h40, 0, 0, 0);
        idle_inputs();
        wait_done();

        // tohost beats the eighth loop retirement in the same cycle
        do_start(1'b0);
        push(1'b0, 2'd1, 32'd2, 32'd12, 32'd8);
        for (int i = 0; i < 7; i++) step(1, 32'h40, 0, 0, 0);
        step(1, 32'h40, 1, TOHOST, 5);
        idle_inputs();
        wait_done();

        // self loop beats timeout when both land on cycle 50
        do_start(1'b0);
        push(1'b1, 2'd2, 32'd0, 32'd54, 32'd8);
        for (int i = 0; i < 42; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 32'h80, 0, 0, 0);
        idle_inputs();
        wait_done();

        // timeout with start held high throughout; must not re-trigger in RUN
        do_start(1'b1);
        push(1'b0, 2'd3, 32'd0, 32'd54, 32'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("timeout_not_yet", done, 0);
        wait_done();
        start = 1'b0;
        tick();

        // reset asserted during DRAIN aborts immediately
        do_start(1'b0);
        step(0, 0, 1, TOHOST, 1);
        step(0, 0, 0, 0, 0);
        idle_inputs();
        chk("drain_running", running, 1);
        rst = 1'b0;
        #2;
        chk("abort_core_rst", core_rst, 1);
        chk("abort_running", running, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        chk("abort_cause", halt_cause, 0);
        chk("abort_cycles", cycle_count, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("abort_stays_idle", done, 0);
        chk("abort_idle_core_rst", core_rst, 1);

        // fresh run after abort
        do_start(1'b0);
        push(1'b1, 2'd1, 32'd0, 32'd5, 32'd0);
        step(0, 0, 1, TOHOST, 1);
        idle_inputs();
        wait_done();

        tick();
        tick();
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
